// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: bus stores feed an 8-entry TX FIFO and are sent 8N1, LSB first.
// Optional even-parity bit (8E1) is enabled by defining UART_TX_PARITY_EN.
module mmio_uart_tx #(
  parameter int DATA_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 8,
  parameter int DEFAULT_DIV = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sel,
  input  logic [3:0]            addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [3:0]            wmask,
  input  logic                  we,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  tx
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

  state_e        state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [2:0]    bit_q, bit_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   divl_q, divl_d;
  logic [15:0]   div_q, div_d;
  logic          tx_q, tx_d;
  logic          ovf_q, ovf_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic          wr_s, push_req_s, stat_wr_s, div_wr_s;
  logic          push_ok_s, pop_s;
  logic          fifo_empty_s, fifo_full_s;
  logic [15:0]   div_eff_s;
  logic [31:0]   count_ext_s;
  logic [3:0]    count_sat_s;
  logic [31:0]   status_s, rdata_s;
  logic          unused_bits_s;

  assign wr_s         = sel & we;
  assign push_req_s   = wr_s && (addr[3:2] == 2'd0) && wmask[0];
  assign stat_wr_s    = wr_s && (addr[3:2] == 2'd1) && wmask[0];
  assign div_wr_s     = wr_s && (addr[3:2] == 2'd2);
  assign div_eff_s    = (div_q == 16'd0) ? 16'd1 : div_q;
  assign fifo_empty_s = (count_q == CW'(0));
  assign fifo_full_s  = (count_q == CW'(FIFO_DEPTH));
  assign count_ext_s  = 32'(count_q);
  assign count_sat_s  = (count_ext_s > 32'd15) ? 4'd15 : count_ext_s[3:0];
  assign unused_bits_s = ^{data_in[DATA_WIDTH-1:16], addr[1:0], wmask[3:2]};
  assign tx           = tx_q;

  // Frame sequencer: a pop always restarts at START, from IDLE or straight out of STOP.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    par_d   = par_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    divl_d  = divl_q;
    pop_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (cnt_q == 16'd0) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
          cnt_d   = divl_q - 16'd1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (cnt_q == 16'd0) begin
          cnt_d = divl_q - 16'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == 16'd0) begin
          state_d = S_STOP;
          cnt_d   = divl_q - 16'd1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == 16'd0) begin
          if (!fifo_empty_s) begin
            pop_s = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Divisor is captured here so DIV writes mid-frame only affect the next frame.
    if (pop_s) begin
      state_d = S_START;
      shift_d = mem_q[rptr_q];
      par_d   = even_parity(mem_q[rptr_q]);
      divl_d  = div_eff_s;
      cnt_d   = div_eff_s - 16'd1;
    end else begin
      divl_d = divl_d;
    end
  end

  // Line level derived from the next state so tx is a clean register output.
  always_comb begin
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = par_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  // FIFO bookkeeping; a push at full is accepted only when a pop frees a slot this cycle.
  always_comb begin
    push_ok_s = push_req_s && (!fifo_full_s || pop_s);
    if (push_ok_s) begin
      wptr_d = wptr_q + PW'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_s) begin
      rptr_d = rptr_q + PW'(1);
    end else begin
      rptr_d = rptr_q;
    end
    case ({push_ok_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Sticky overflow and byte-lane DIV updates.
  always_comb begin
    if (push_req_s && !push_ok_s) begin
      ovf_d = 1'b1;
    end else if (stat_wr_s) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    div_d = div_q;
    if (div_wr_s) begin
      if (wmask[0]) begin
        div_d[7:0] = data_in[7:0];
      end else begin
        div_d[7:0] = div_q[7:0];
      end
      if (wmask[1]) begin
        div_d[15:8] = data_in[15:8];
      end else begin
        div_d[15:8] = div_q[15:8];
      end
    end else begin
      div_d = div_q;
    end
  end

  // Load data path: combinational from addr, reflecting the registered state.
  always_comb begin
    status_s      = 32'd0;
    status_s[0]   = fifo_full_s;
    status_s[1]   = fifo_empty_s;
    status_s[2]   = (state_q != S_IDLE);
    status_s[3]   = ovf_q;
    status_s[7:4] = count_sat_s;
`ifdef UART_TX_PARITY_EN
    status_s[8]   = 1'b1;
`endif
    case (addr[3:2])
      2'd1:    rdata_s = status_s;
      2'd2:    rdata_s = {16'd0, div_q};
      default: rdata_s = 32'd0;
    endcase
    data_out = DATA_WIDTH'(rdata_s);
  end

  // State registers with synchronous reset; reset aborts any frame and flushes the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      shift_q <= 8'd0;
      par_q   <= 1'b0;
      bit_q   <= 3'd0;
      cnt_q   <= 16'd0;
      divl_q  <= 16'(DEFAULT_DIV);
      div_q   <= 16'(DEFAULT_DIV);
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      divl_q  <= divl_d;
      div_q   <= div_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // FIFO storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wptr_q] <= data_in[7:0];
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: register vector table, scoreboard-fed serial monitor,
// and hand-written sequences for frame timing, overflow, mid-frame DIV change and reset.
module tb_mmio_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int          NBITS = 11;
  localparam logic [31:0] PB    = 32'h100;
`else
  localparam int          NBITS = 10;
  localparam logic [31:0] PB    = 32'h0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  addr = 4'h0;
  logic [3:0]  wmask = 4'h0;
  logic [31:0] data_in = 32'h0;
  logic [31:0] data_out;
  logic        tx;

  mmio_uart_tx #(.DATA_WIDTH(32), .FIFO_DEPTH(8), .DEFAULT_DIV(16)) dut (
    .clk(clk), .rst(rst), .sel(sel), .addr(addr), .data_in(data_in),
    .wmask(wmask), .we(we), .data_out(data_out), .tx(tx)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [7:0]  sb_q[$];
  int          start_q[$];
  logic [15:0] model_div = 16'd16;
  bit          mon_en = 1'b1;
  bit          mon_busy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_access(input bit s, input bit w, input logic [3:0] a,
                            input logic [31:0] d, input logic [3:0] m);
    sel = s; we = w; addr = a; data_in = d; wmask = m;
    @(posedge clk);
    #1;
    if (s && w && a[3:2] == 2'd2) begin
      if (m[0]) model_div[7:0] = d[7:0];
      if (m[1]) model_div[15:8] = d[15:8];
    end
    sel = 1'b0; we = 1'b0; wmask = 4'h0;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit accept);
    if (accept) sb_q.push_back(b);
    bus_access(1'b1, 1'b1, 4'h0, {24'h0, b}, 4'h1);
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] r);
    sel = 1'b1; we = 1'b0; addr = a;
    #1;
    r = data_out;
    sel = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    logic [31:0] r;
    n = 0;
    while (n <= budget) begin
      rd(4'h4, r);
      if (r[2] == 1'b0 && sb_q.size() == 0 && !mon_busy) break;
      @(posedge clk); #1;
      n++;
    end
    check("idle_timeout", {31'd0, n > budget}, 32'd0);
  endtask

  // Single byte from idle: checks push/pop visibility, tx start and busy duration.
  task automatic measure_single(input logic [7:0] b, input int d, input string name);
    logic [31:0] r;
    int n;
    push_byte(b, 1'b1);
    rd(4'h4, r);
    check({name, "_pushed"}, r, 32'h10 | PB);
    @(posedge clk); #1;
    rd(4'h4, r);
    check({name, "_popped"}, r, 32'h6 | PB);
    check({name, "_start_tx"}, {31'd0, tx}, 32'd0);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      rd(4'h4, r);
    end while (r[2] == 1'b1 && n < 5000);
    check({name, "_busy_len"}, n, NBITS * d);
    wait_idle(200);
  endtask

  // Serial monitor: decodes each frame against the next scoreboard byte, sample by sample.
  always begin : monitor
    int d, nb_bad, b, j;
    logic [7:0] exp, got;
    logic [10:0] fb;
    bit aborted;
    @(negedge clk);
    if (mon_en && tx === 1'b0) begin
      mon_busy = 1'b1;
      d = (model_div == 16'd0) ? 1 : int'(model_div);
      if (sb_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb_empty: frame started at cycle %0d with no byte expected", cyc);
        exp = 8'h00;
      end else begin
        exp = sb_q.pop_front();
      end
      start_q.push_back(cyc);
      fb = 11'h7FF;
      fb[0] = 1'b0;
      for (int i = 0; i < 8; i++) fb[i+1] = exp[i];
      if (NBITS == 11) fb[9] = ^exp;
      nb_bad = 0; got = 8'h00; aborted = 1'b0;
      for (int s = 0; s < NBITS * d; s++) begin
        if (s != 0) @(negedge clk);
        if (!mon_en) begin
          aborted = 1'b1;
          break;
        end
        b = s / d; j = s % d;
        if (tx !== fb[b]) nb_bad++;
        if (b >= 1 && b <= 8 && j == d / 2) got[b-1] = tx;
      end
      if (!aborted) begin
        check("frame_data", {24'h0, got}, {24'h0, exp});
        check("frame_shape_bad_samples", nb_bad, 32'd0);
      end
      mon_busy = 1'b0;
    end
  end

  typedef struct {
    bit          wr;
    bit          s;
    bit          w;
    logic [3:0]  a;
    logic [31:0] d;
    logic [3:0]  m;
    logic [31:0] exp;
    string       name;
  } vec_t;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[$];
    logic [31:0] r;

    vt.push_back('{1'b0, 1'b1, 1'b0, 4'h4, 32'h0,        4'h0, 32'h2 | PB, "rst_status"});
    vt.push_back('{1'b0, 1'b1, 1'b0, 4'h8, 32'h0,        4'h0, 32'd16,     "rst_div"});
    vt.push_back('{1'b0, 1'b1, 1'b0, 4'h0, 32'h0,        4'h0, 32'h0,      "txdata_reads0"});
    vt.push_back('{1'b0, 1'b1, 1'b0, 4'hC, 32'h0,        4'h0, 32'h0,      "regc_reads0"});
    vt.push_back('{1'b1, 1'b1, 1'b1, 4'h8, 32'h1234,     4'h1, 32'h0,      ""});
    vt.push_back('{1'b0, 1'b1, 1'b0, 4'h8, 32'h0,        4'h0, 32'h34,     "div_lane0"});
    vt.push_back('{1'b1, 1'b1, 1'b1, 4'h8, 32'hAB00,     4'h2, 32'h0,      ""});
    vt.push_back('{1'b0, 1'b1, 1'b0, 4'h8, 32'h0,        4'h0, 32'hAB34,   "div_lane1"});
    vt.push_back('{1'b1, 1'b1, 1'b1, 4'h8, 32'hFFFF0005, 4'hF, 32'h0,      ""});
    vt.push_back('{1'b0, 1'b1, 1'b0, 4'h8, 32'h0,        4'h0, 32'h5,      "div_full"});
    vt.push_back('{1'b1, 1'b0, 1'b1, 4'h8, 32'h99,       4'hF, 32'h0,      ""});
    vt.push_back('{1'b0, 1'b1, 1'b0, 4'h8, 32'h0,        4'h0, 32'h5,      "div_sel0_ignored"});
    vt.push_back('{1'b1, 1'b1, 1'b0, 4'h8, 32'h77,       4'hF, 32'h0,      ""});
    vt.push_back('{1'b0, 1'b1, 1'b0, 4'h8, 32'h0,        4'h0, 32'h5,      "div_we0_ignored"});
    vt.push_back('{1'b1, 1'b1, 1'b1, 4'h0, 32'h55,       4'hE, 32'h0,      ""});
    vt.push_back('{1'b0, 1'b1, 1'b0, 4'h4, 32'h0,        4'h0, 32'h2 | PB, "no_push_lane0_off"});
    vt.push_back('{1'b1, 1'b0, 1'b1, 4'h0, 32'h11,       4'h1, 32'h0,      ""});
    vt.push_back('{1'b0, 1'b1, 1'b0, 4'h4, 32'h0,        4'h0, 32'h2 | PB, "no_push_sel0"});
    vt.push_back('{1'b1, 1'b1, 1'b1, 4'hC, 32'hFF,       4'hF, 32'h0,      ""});
    vt.push_back('{1'b0, 1'b1, 1'b0, 4'hC, 32'h0,        4'h0, 32'h0,      "regc_write_ignored"});

    // Reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", {31'd0, tx}, 32'd1);
    rst = 1'b0;

    foreach (vt[i]) begin
      if (vt[i].wr) begin
        bus_access(vt[i].s, vt[i].w, vt[i].a, vt[i].d, vt[i].m);
      end else begin
        rd(vt[i].a, r);
        check(vt[i].name, r, vt[i].exp);
      end
    end

    // Single 0xA5 frame at DIV=4
    bus_access(1'b1, 1'b1, 4'h8, 32'd4, 4'h3);
    measure_single(8'hA5, 4, "a5");

    // Three back-to-back frames at DIV=2
    bus_access(1'b1, 1'b1, 4'h8, 32'd2, 4'h3);
    start_q.delete();
    push_byte(8'h01, 1'b1);
    push_byte(8'h02, 1'b1);
    push_byte(8'h03, 1'b1);
    wait_idle(500);
    check("b2b_frames", start_q.size(), 32'd3);
    if (start_q.size() == 3) begin
      check("b2b_gap1", start_q[1] - start_q[0], NBITS * 2);
      check("b2b_gap2", start_q[2] - start_q[1], NBITS * 2);
    end

    // Overflow at DIV=100: first byte pops, 8 stored, 10th dropped
    bus_access(1'b1, 1'b1, 4'h8, 32'd100, 4'h3);
    for (int i = 0; i < 9; i++) push_byte(8'h10 + 8'(i), 1'b1);
    push_byte(8'h19, 1'b0);
    rd(4'h4, r);
    check("ovf_status", r, 32'h8D | PB);
    bus_access(1'b1, 1'b1, 4'h4, 32'h0, 4'h1);
    rd(4'h4, r);
    check("ovf_cleared", r, 32'h85 | PB);
    bus_access(1'b1, 1'b1, 4'h8, 32'd1, 4'h3);
    wait_idle(3000);

    // DIV change mid-frame affects only the following frame
    bus_access(1'b1, 1'b1, 4'h8, 32'd4, 4'h3);
    start_q.delete();
    push_byte(8'h3C, 1'b1);
    push_byte(8'hC3, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    bus_access(1'b1, 1'b1, 4'h8, 32'd8, 4'h3);
    wait_idle(500);
    check("midframe_frames", start_q.size(), 32'd2);
    if (start_q.size() == 2) check("midframe_first_len", start_q[1] - start_q[0], NBITS * 4);

    // DIV=0 behaves as 1; parity pattern byte at DIV=2
    bus_access(1'b1, 1'b1, 4'h8, 32'd0, 4'h3);
    measure_single(8'h5A, 1, "div0");
    bus_access(1'b1, 1'b1, 4'h8, 32'd2, 4'h3);
    measure_single(8'h07, 2, "b07");

    // Reset during DATA bit 3
    bus_access(1'b1, 1'b1, 4'h8, 32'd4, 4'h3);
    push_byte(8'h00, 1'b1);
    repeat (18) @(posedge clk);
    #1;
    check("pre_rst_tx", {31'd0, tx}, 32'd0);
    mon_en = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_tx", {31'd0, tx}, 32'd1);
    rd(4'h4, r);
    check("rst_mid_status", r, 32'h2 | PB);
    rd(4'h8, r);
    check("rst_mid_div", r, 32'd16);
    rst = 1'b0;
    sb_q.delete();
    model_div = 16'd16;
    @(posedge clk); #1;
    mon_en = 1'b1;
    measure_single(8'h81, 16, "post_rst");

    check("sb_leftover", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
